// File: rtl/arb4_mux_ctrl_if.sv
// Control bundle between the 4:1 mux arbiter and its requesters/consumer.
// The arbiter side uses master; the requester/consumer side uses slave.
interface arb4_mux_ctrl_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ack;
  logic       busy;

  modport master (
    input  req, out_ready,
    output sel, grant, out_valid, ack, busy
  );

  modport slave (
    output req, out_ready,
    input  sel, grant, out_valid, ack, busy
  );
endinterface

// File: rtl/arb4_mux_ctrl.sv
// Round-robin owner selection and burst sequencing for a shared 4:1 data mux.
// Grants are held for at most MAX_BURST accepted words or until the owner withdraws.
module arb4_mux_ctrl #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  arb4_mux_ctrl_if.master   bus
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [SEL_W-1:0] win_idx;
  logic [SEL_W-1:0] cand;
  logic             win_found;

  logic [N_REQ-1:0] grant_c;
  logic [N_REQ-1:0] ack_c;
  logic             out_valid_c;
  logic             busy_c;
  logic             accept_c;
  logic             last_c;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr_q + SEL_W'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_c     = '0;
    ack_c       = '0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept_c    = 1'b0;
    last_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          cnt_d   = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        grant_c     = N_REQ'(1) << sel_q;
        busy_c      = 1'b1;
        out_valid_c = bus.req[sel_q];
        accept_c    = out_valid_c && bus.out_ready;
        last_c      = (5'(cnt_q) + 5'd1) == 5'(MAX_BURST);
        if (!out_valid_c) begin
          // Owner withdrew: abandon the word, no acknowledge.
          state_d = ST_IDLE;
          ptr_d   = sel_q + SEL_W'(1);
        end else if (accept_c) begin
          ack_c = grant_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_c) begin
            state_d = ST_IDLE;
            ptr_d   = sel_q + SEL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An accept coinciding with reset is discarded.
  assign bus.ack       = rst ? '0 : ack_c;
  assign bus.grant     = grant_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_arb4_mux_ctrl.sv
// Bench for arb4_mux_ctrl: directed scenarios plus random traffic, checked every cycle
// against a transaction-level owner/pointer/count model.
module tb_arb4_mux_ctrl;

  localparam int unsigned MAXB = 4;

  logic clk;
  logic rst;

  arb4_mux_ctrl_if bus_if ();

  arb4_mux_ctrl #(.MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner index (-1 = none), rotating pointer, last select, words in burst.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic [3:0] rq, input logic rdy);
    logic [3:0] e_grant, e_ack;
    logic       e_valid;
    @(negedge clk);
    rst              = r;
    bus_if.req       = rq;
    bus_if.out_ready = rdy;
    #1;
    e_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_valid = (m_owner >= 0) && rq[m_owner];
    e_ack   = (e_valid && rdy && !r) ? e_grant : 4'b0000;
    chk("grant",     32'(bus_if.grant),     32'(e_grant));
    chk("sel",       32'(bus_if.sel),       32'(m_sel));
    chk("out_valid", 32'(bus_if.out_valid), 32'(e_valid));
    chk("ack",       32'(bus_if.ack),       32'(e_ack));
    chk("busy",      32'(bus_if.busy),      32'(m_owner >= 0));

    if (r) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (m_owner < 0 && rq[idx]) begin
          m_owner = idx; m_sel = idx; m_cnt = 0;
        end
      end
    end else if (!rq[m_owner]) begin
      m_ptr = (m_owner + 1) % 4; m_owner = -1;
    end else if (rdy) begin
      m_cnt++;
      if (m_cnt == int'(MAXB)) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end
    end
  endtask

  initial begin
    logic [3:0] rq;
    rst              = 1'b1;
    bus_if.req       = 4'b1111;
    bus_if.out_ready = 1'b1;
    @(posedge clk);

    // Reset held with all requesting, then rotation through all four owners.
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b0, 4'b1111, 1'b1);

    // Single requester 2 repeatedly re-granted.
    step(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'b0100, 1'b1);

    // Backpressure on owner 1.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // Owner 3 withdraws after one word; requester 0 takes over.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b1000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 1'b1);

    // Reset in the middle of owner 2's burst.
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0100, 1'b1);
    step(1'b1, 4'b0110, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0110, 1'b1);

    // Random traffic: mostly-held requests, random readiness, occasional reset.
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(($urandom_range(0, 127) == 0), rq, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arb4_mux_ctrl.md
# arb4_mux_ctrl

Round-robin arbiter and sequencer for the shared 4:1 32-bit select mux that merges four requester data buses onto one downstream port. It chooses which requester owns the mux, drives the 2-bit mux select, and runs a valid/ready handshake with the consumer. It returns a per-word acknowledge to the owning requester and bounds each ownership to a burst of at most `MAX_BURST` words. It sits between the four producers and the mux/consumer. The data words themselves never pass through this block.

## Interface
- `MAX_BURST`, 4: maximum words accepted per grant; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  `req[i]` high means requester i has a word on its mux input `I<i>`.
- `sel`  out  2  mux select, wired to the mux `s` input; binary index of the owner.
- `grant`  out  4  one-hot owner indication; all zero when no owner.
- `out_valid`  out  1  mux output holds a valid word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `ack`  out  4  one-hot, one-cycle pulse: the word of requester i was accepted.
- `busy`  out  1  high while a grant is held (state SERVE).

## Operation
- Registered state: `state` (IDLE/SERVE), `sel[1:0]`, `ptr[1:0]` (highest-priority index), `cnt[3:0]` (words accepted in the current burst).
- Priority order in IDLE is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, computed mod 4. The winner is the first index with `req` high.
- **IDLE**:
  - `grant`, `out_valid`, `ack`, `busy` are 0.
  - If any `req` is high, the next edge loads `sel` with the winner, clears `cnt`, and moves to SERVE.
  - If `req` is 0, the block stays in IDLE and `ptr` is unchanged.
- **SERVE**:
  - `grant` = onehot(`sel`); `busy` = 1.
  - `out_valid` = `req[sel]`, combinational from `req`.
  - When `out_valid` & `out_ready`: `ack[sel]` = 1 in the same cycle, and `cnt` increments at the edge.
  - Release to IDLE at the edge, with `ptr` <= `sel`+1 (wraps 3→0), when either:
    - an accept occurs and `cnt`+1 == `MAX_BURST`, or
    - `req[sel]` is 0 (requester withdrew; no ack is issued).
  - Otherwise the block stays in SERVE, and `sel` is frozen for the whole grant.
- Requester rule: hold `req` and the data stable until `ack`. Dropping `req` before `ack` abandons the word and ends the grant.
- Requests from non-owners are ignored during SERVE. No preemption.
- `out_ready` is ignored when `out_valid` = 0.
- `cnt` is 4 bits wide and never exceeds `MAX_BURST`.

## Timing
- Reset values:
  - `state` = IDLE.
  - `sel` = 0, `ptr` = 0, `cnt` = 0.
  - Therefore `grant` = 0, `out_valid` = 0, `ack` = 0, `busy` = 0.
- `rst` asserted mid-burst:
  - At that edge the block returns to IDLE and `ptr` returns to 0.
  - An accept in the reset cycle is discarded: `ack` is forced 0 while `rst` is high.
- Latency: `req` rising in cycle N (block in IDLE) gives `grant` and `out_valid` high in cycle N+1.
- Back-to-back words within a burst: one word per cycle while `out_ready` = 1.
- Every release costs exactly one IDLE cycle before the next grant, so handover gap = 1 cycle.
- Throughput with all four requesting continuously and `out_ready` = 1: `MAX_BURST` words per `MAX_BURST`+1 cycles.
- `out_ready` low stalls the burst indefinitely. `ack` stays 0, and `cnt` and `sel` hold.
- Withdraw and accept in the same cycle cannot occur, because an accept requires `req[sel]` = 1.

## Test plan
- **Reset/idle**:
  - Stimulus: assert `rst` for 2 cycles with `req` = 4'b1111.
  - Response: `grant` = 0, `sel` = 0, `out_valid` = 0, `busy` = 0, `ack` = 0 throughout.
  - After release, `grant` = 4'b0001 one cycle later.
- **Single burst, `MAX_BURST` = 4**:
  - Stimulus: `req` = 4'b0100 held, `out_ready` = 1.
  - Response: `sel` = 2, `ack[2]` pulses in 4 consecutive cycles, then one IDLE cycle, then a new grant to 2.
- **Round-robin rotation**:
  - Stimulus: `req` = 4'b1111 held, `out_ready` = 1, from reset.
  - Response: grant order 0,1,2,3,0; each burst has 4 acks; a 1-cycle gap between bursts; `ptr` wraps 3→0.
- **Backpressure**:
  - Stimulus: owner 1; `out_ready` toggles 1,0,0,1,1,1.
  - Response: `ack[1]` only in ready cycles; release after the 4th ack; `sel` is stable while stalled.
- **Withdraw**:
  - Stimulus: owner 3, 1 word acked, then `req[3]` drops while `req[0]` = 1.
  - Response: no further `ack[3]`; IDLE for 1 cycle; next grant to 0 (`ptr` = 0).
- **Reset mid-burst**:
  - Stimulus: owner 2 after 2 acks; `rst` pulsed with `out_ready` = 1.
  - Response: no ack in the reset cycle; state IDLE; with `req` = 4'b0110, the next grant is to 1.
